// File: rtl/bp_profiler_pkg.sv
// bp_profiler_pkg: drain FSM states and stream header layout for the commit profiler
package bp_profiler_pkg;

    typedef enum logic [1:0] {
        e_drain_idle,
        e_drain_header,
        e_drain_drain,
        e_drain_done
    } drain_state_e;

    localparam int header_magic_offset_lp = 24;
    localparam int header_magic_width_lp  = 8;
    localparam int header_seq_offset_lp   = 16;
    localparam int header_seq_width_lp    = 8;
    localparam int header_count_width_lp  = 16;

    localparam logic [header_magic_width_lp-1:0] header_magic_default_lp = 8'hA5;

    function automatic logic [31:0] make_header(
        input logic [header_magic_width_lp-1:0] magic,
        input logic [header_seq_width_lp-1:0]   seq,
        input logic [header_count_width_lp-1:0] count
    );
        logic [31:0] h;
        h = '0;
        h[header_magic_offset_lp +: header_magic_width_lp] = magic;
        h[header_seq_offset_lp +: header_seq_width_lp]     = seq;
        h[0 +: header_count_width_lp]                      = count;
        return h;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up: up counter with synchronous clear and async reset
module bsg_counter_clear_up #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i)
            count_o <= '0;
        else if (clear_i)
            count_o <= '0;
        else if (up_i)
            count_o <= count_o + width_p'(1);

endmodule

// File: rtl/bsg_dff_en.sv
// bsg_dff_en: enabled register with no reset
module bsg_dff_en #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i)
        if (en_i)
            data_o <= data_i;

endmodule

// File: rtl/bsg_mux.sv
// bsg_mux: selects one word out of a flattened word vector
module bsg_mux #(
    parameter int els_p     = 2,
    parameter int width_p   = 32,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [lg_els_lp-1:0]     sel_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] els [els_p];

    for (genvar i = 0; i < els_p; i++) begin : g_el
        assign els[i] = data_i[i*width_p +: width_p];
    end

    assign data_o = els[sel_i];

endmodule

// File: rtl/bp_profiler_drain.sv
// bp_profiler_drain: snapshots the counter bank on request and streams it out behind a header word
module bp_profiler_drain
    import bp_profiler_pkg::*;
#(
    parameter int         num_counters_p = 79,
    parameter int         width_p        = 32,
    parameter logic [7:0] header_magic_p = header_magic_default_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] counters_i [num_counters_p],
    input  logic               start_v_i,
    input  logic               clear_on_start_i,
    output logic               start_ready_o,
    input  logic               abort_i,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               clear_o,
    output logic               done_o,
    output logic [7:0]         seq_o
);

    localparam int idx_w_lp = (num_counters_p > 1) ? $clog2(num_counters_p) : 1;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_counters_p - 1);

    drain_state_e state_r, state_n;
    logic clear_req_r, start, accept, last;
    logic [idx_w_lp-1:0] idx;
    logic [num_counters_p*width_p-1:0] live_flat, snap_flat;
    logic [width_p-1:0] snap_word, header_word;

    for (genvar i = 0; i < num_counters_p; i++) begin : g_flat
        assign live_flat[i*width_p +: width_p] = counters_i[i];
    end

    assign start  = (state_r == e_drain_idle) && start_v_i;
    assign accept = v_o && yumi_i;
    assign last   = idx == last_idx_lp;

    bsg_dff_en #(.width_p(num_counters_p*width_p)) snapshot (
        .clk_i,
        .en_i  (start),
        .data_i(live_flat),
        .data_o(snap_flat)
    );

    bsg_counter_clear_up #(.width_p(idx_w_lp)) index (
        .clk_i,
        .reset_i,
        .clear_i(state_r == e_drain_header && accept),
        .up_i   (state_r == e_drain_drain && accept && !last),
        .count_o(idx)
    );

    bsg_mux #(.els_p(num_counters_p), .width_p(width_p)) out_mux (
        .data_i(snap_flat),
        .sel_i (idx),
        .data_o(snap_word)
    );

    assign header_word = width_p'(make_header(header_magic_p, seq_o, 16'(num_counters_p)));

    // clear_req_r lives for exactly one cycle, which is the first HEADER cycle
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_r     <= e_drain_idle;
            clear_req_r <= 1'b0;
            seq_o       <= '0;
        end else begin
            state_r     <= state_n;
            clear_req_r <= start && clear_on_start_i;
            seq_o       <= seq_o + 8'(state_r == e_drain_done);
        end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_drain_idle:   state_n = start_v_i ? e_drain_header : e_drain_idle;
            e_drain_header: state_n = abort_i ? e_drain_idle : yumi_i ? e_drain_drain : e_drain_header;
            e_drain_drain:  state_n = abort_i ? e_drain_idle : (yumi_i && last) ? e_drain_done : e_drain_drain;
            e_drain_done:   state_n = e_drain_idle;
        endcase
    end

    assign start_ready_o = state_r == e_drain_idle;
    assign v_o           = (state_r == e_drain_header) || (state_r == e_drain_drain);
    assign clear_o       = (state_r == e_drain_header) && clear_req_r;
    assign done_o        = state_r == e_drain_done;
    assign data_o        = (state_r == e_drain_header) ? header_word :
                           (state_r == e_drain_drain)  ? snap_word   : '0;

endmodule

// File: tb/tb_bp_profiler_drain.sv
// tb_bp_profiler_drain: scoreboard bench for the profiler drain stream
module tb_bp_profiler_drain;

    localparam int n_lp = 79;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] counters [n_lp];
    logic start_v, clear_on_start, start_ready, abort, v, yumi, clear, done;
    logic [31:0] data;
    logic [7:0] seq;

    bp_profiler_drain #(.num_counters_p(n_lp), .width_p(32), .header_magic_p(8'hA5)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .counters_i      (counters),
        .start_v_i       (start_v),
        .clear_on_start_i(clear_on_start),
        .start_ready_o   (start_ready),
        .abort_i         (abort),
        .data_o          (data),
        .v_o             (v),
        .yumi_i          (yumi),
        .clear_o         (clear),
        .done_o          (done),
        .seq_o           (seq)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    int checks = 0, errors = 0;
    int cyc = 0, acc_cnt = 0, done_cnt = 0, clr_cnt = 0, clr_cyc = -1, t_hdr = 0;
    int yumi_mode = 0;
    bit inc_en = 0;
    logic [7:0] seq_m = 8'd0;
    logic prev_stall = 1'b0, abort_prev = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic init_counters();
        foreach (counters[i]) counters[i] = 32'(i * 3 + 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // counter bank model: optional free-running increment, zeroed by clear_o
    initial begin
        bit clr_now;
        forever begin
            @(negedge clk);
            clr_now = clear;
            @(posedge clk);
            #2;
            if (clr_now) foreach (counters[i]) counters[i] = '0;
            else if (inc_en) foreach (counters[i]) counters[i] = counters[i] + 1;
        end
    end

    // consumer: 0 = always take, 1 = pattern 1,0,0,1, 2 = stall first 3 valid cycles
    initial begin
        int vcnt;
        vcnt = 0;
        yumi = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (v && !reset) begin
                case (yumi_mode)
                    1: yumi = (vcnt % 4 == 0) || (vcnt % 4 == 3);
                    2: yumi = vcnt >= 3;
                    default: yumi = 1'b1;
                endcase
                vcnt++;
            end else begin
                yumi = 1'b0;
                vcnt = 0;
            end
        end
    end

    // monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (yumi && !v) begin
                errors++;
                $display("FAIL yumi_without_v at cycle %0d", cyc);
            end
            if (prev_stall && !abort_prev) begin
                check("stall_v", 32'(v), 32'd1);
                check("stall_data", data, prev_data);
            end
            if (v && yumi) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h expected none", data);
                end else begin
                    check($sformatf("word%0d", acc_cnt), data, exp_q.pop_front());
                end
                acc_cnt++;
            end
            if (clear) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_v", 32'(v), 32'd0);
                check("done_ready", 32'(start_ready), 32'd0);
            end
            prev_stall = v && !yumi;
            prev_data  = data;
            abort_prev = abort;
        end
    end

    task automatic start_snap(input bit clr);
        int b;
        b = 0;
        while (!start_ready && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("start_ready", 32'(start_ready), 32'd1);
        start_v = 1'b1;
        clear_on_start = clr;
        @(negedge clk);
        exp_q.push_back({8'hA5, seq_m, 16'(n_lp)});
        foreach (counters[i]) exp_q.push_back(counters[i]);
        @(posedge clk);
        #1;
        t_hdr = cyc;
        start_v = 1'b0;
        clear_on_start = 1'b0;
    endtask

    task automatic finish_snap(input int d0);
        int b;
        b = 0;
        while (done_cnt == d0 && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt - d0), 32'd1);
        seq_m++;
        check("seq", 32'(seq), 32'(seq_m));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int d0, a0, c0, b;
        logic [7:0] s0;
        start_v = 1'b0;
        clear_on_start = 1'b0;
        abort = 1'b0;
        init_counters();
        #2 reset = 1'b1;
        #1;
        check("rst_v", 32'(v), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_seq", 32'(seq), 32'd0);
        check("rst_ready", 32'(start_ready), 32'd1);
        check("rst_data", data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // basic drain
        d0 = done_cnt; a0 = acc_cnt; c0 = clr_cnt;
        start_snap(1'b0);
        check("hdr_latency_v", 32'(v), 32'd1);
        check("hdr_first", data, 32'hA500004F);
        finish_snap(d0);
        check("basic_words", 32'(acc_cnt - a0), 32'd80);
        check("basic_no_clear", 32'(clr_cnt - c0), 32'd0);

        // coherence: counters move every cycle during the drain
        inc_en = 1'b1;
        d0 = done_cnt;
        start_snap(1'b0);
        repeat (20) begin @(posedge clk); #1; end
        check("busy_not_ready", 32'(start_ready), 32'd0);
        finish_snap(d0);
        inc_en = 1'b0;
        init_counters();

        // backpressure
        yumi_mode = 1;
        d0 = done_cnt; a0 = acc_cnt;
        start_snap(1'b0);
        finish_snap(d0);
        check("bp_words", 32'(acc_cnt - a0), 32'd80);
        yumi_mode = 0;

        // clear with a stalled header
        yumi_mode = 2;
        d0 = done_cnt; c0 = clr_cnt;
        start_snap(1'b1);
        finish_snap(d0);
        check("clear_pulses", 32'(clr_cnt - c0), 32'd1);
        check("clear_cycle", 32'(clr_cyc), 32'(t_hdr));
        yumi_mode = 0;
        init_counters();

        // abort after word 10
        d0 = done_cnt; a0 = acc_cnt; s0 = seq_m;
        start_snap(1'b0);
        b = 0;
        while (acc_cnt - a0 < 11 && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("abort_reached", 32'(acc_cnt - a0), 32'd11);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_v", 32'(v), 32'd0);
        check("abort_consumed", 32'(acc_cnt - a0), 32'd12);
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_seq", 32'(seq), 32'(s0));
        d0 = done_cnt;
        start_snap(1'b0);
        finish_snap(d0);

        // async reset mid-drain
        d0 = done_cnt;
        start_snap(1'b0);
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("arst_v", 32'(v), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_clear", 32'(clear), 32'd0);
        check("arst_seq", 32'(seq), 32'd0);
        check("arst_ready", 32'(start_ready), 32'd1);
        check("arst_data", data, 32'd0);
        exp_q.delete();
        seq_m = 8'd0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);

        // 257 snapshots so the header sequence wraps 0xFF -> 0x00
        for (int k = 0; k < 257; k++) begin
            d0 = done_cnt;
            start_snap(1'b0);
            if (k == 255) check("wrap_hdr_ff", 32'(data[23:16]), 32'hFF);
            if (k == 256) check("wrap_hdr_00", 32'(data[23:16]), 32'h00);
            if (k == 5) begin
                repeat (10) begin @(posedge clk); #1; end
                start_v = 1'b1;
                @(posedge clk);
                #1;
                start_v = 1'b0;
            end
            finish_snap(d0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
